writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter p_num_pipes, default 2, the number of execute pipes competing for writeback (1..8).
REQ-002 SHALL have parameter p_seq_num_bits, default 3, the sequence number width.
REQ-003 SHALL have parameter p_policy, default 0, the grant policy: 0 = oldest-first, 1 = round-robin.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_val, input, p_num_pipes bits: per-pipe request valid.
REQ-007 SHALL have port in_rdy, output, p_num_pipes bits: per-pipe grant/ready.
REQ-008 SHALL have ports in_pc, in_seq_num, in_waddr, in_wdata and in_wen, all inputs, each a flattened p_num_pipes x {32, p_seq_num_bits, 5, 32, 1} bus; pipe i occupies slice i.
REQ-009 SHALL have port head_seq_num, input, p_seq_num_bits bits: sequence number of the next instruction to commit (age reference).
REQ-010 SHALL have ports out_val (output, 1 bit) and out_rdy (input, 1 bit): the downstream writeback handshake.
REQ-011 SHALL have ports out_pc, out_seq_num, out_waddr, out_wdata and out_wen, all outputs: the registered winning message.
REQ-012 SHALL have port out_pipe, output, $clog2(p_num_pipes) bits (min 1): index of the pipe that sourced the out_* message.

Function
REQ-013 SHALL transfer on a port only when its val and rdy are both high in the same cycle.
REQ-014 SHALL hold one output register; it can_accept when out_val=0 or out_rdy=1 (pipelined, no bubble).
REQ-015 SHALL, when can_accept and any in_val is set, assert in_rdy for exactly one valid pipe (the winner); all other in_rdy are 0.
REQ-016 SHALL keep in_rdy all-zero when can_accept=0 or no in_val is set; in_rdy SHALL NOT depend on in_rdy (no loops).
REQ-017 SHALL, in oldest-first mode, compute age_i = (in_seq_num_i - head_seq_num) mod 2^p_seq_num_bits and grant the valid pipe with the smallest age_i; equal ages go to the lowest index.
REQ-018 SHALL, in round-robin mode, grant the first valid pipe at or after rr_ptr (wrapping modulo p_num_pipes), then set rr_ptr = winner+1 mod p_num_pipes; rr_ptr SHALL be unchanged when there is no grant.
REQ-019 SHALL load the winner's fields and index into out_* on the grant edge and set out_val=1, giving a latency of one cycle from in transfer to out_val.
REQ-020 SHALL clear out_val when out_rdy=1 and there is no new grant; it SHALL hold out_* stable while out_val=1 and out_rdy=0.
REQ-021 SHALL, when out_rdy=1 and a grant occur in the same cycle, replace the output with the new winner so that out_val stays 1 (full throughput, one message/cycle).
REQ-022 SHALL treat head_seq_num as combinational for arbitration only; it is never registered.
REQ-023 SHALL, for p_num_pipes=1, reduce to a single-entry pipeline register with out_pipe=0.

Reset
REQ-024 SHALL, while rst=1, asynchronously force out_val=0, rr_ptr=0, and out_pc, out_seq_num, out_waddr, out_wdata, out_wen and out_pipe to 0.
REQ-025 SHALL, while rst=1, hold all in_rdy at 0.
REQ-026 SHALL, when rst is asserted mid-transfer, discard the held output message; no partial message is emitted after rst deasserts.

Verification
REQ-027 The bench SHALL cover this case, oldest-first with wrap: p_num_pipes=2, head=6, pipe0 seq=1, pipe1 seq=7 both valid -> pipe1 granted first (age 1 < age 3); next cycle pipe0 granted; out_seq_num sequence 7 then 1.
REQ-028 The bench SHALL cover this case, back-pressure: out_rdy=0 for 3 cycles with out_val=1 -> in_rdy=0 throughout and out_* unchanged; on out_rdy=1 the next winner appears the following cycle.
REQ-029 The bench SHALL cover this case, round-robin fairness: p_policy=1, 3 pipes continuously valid, out_rdy=1 -> out_pipe sequence 0,1,2,0,1,2 at one message/cycle.
REQ-030 The bench SHALL cover this case, simultaneous drain and grant: out_val=1, out_rdy=1, pipe0 valid with pc=0x200 -> out_val stays 1 and out_pc=0x200 next cycle.
REQ-031 The bench SHALL cover this case, reset mid-operation: rst pulsed while out_val=1 and out_rdy=0 -> out_val=0 immediately (asynchronous), rr_ptr=0, and no stale message after release.
REQ-032 The bench SHALL cover this case, idle: all in_val=0 with out_rdy=1 -> out_val falls to 0 one cycle after the last transfer and in_rdy stays 0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: picks one execute pipe per cycle (oldest-first or round-robin)
// and registers its writeback message behind a one-entry, no-bubble output stage.
module writeback_arbiter #(
  parameter int p_num_pipes = 2,
  parameter int p_seq_num_bits = 3,
  parameter int p_policy = 0,
  localparam int lp_pipe_bits = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [p_num_pipes-1:0]                in_val,
  output logic [p_num_pipes-1:0]                in_rdy,
  input  logic [32*p_num_pipes-1:0]             in_pc,
  input  logic [p_seq_num_bits*p_num_pipes-1:0] in_seq_num,
  input  logic [5*p_num_pipes-1:0]              in_waddr,
  input  logic [32*p_num_pipes-1:0]             in_wdata,
  input  logic [p_num_pipes-1:0]                in_wen,
  input  logic [p_seq_num_bits-1:0]             head_seq_num,
  output logic                                  out_val,
  input  logic                                  out_rdy,
  output logic [31:0]                           out_pc,
  output logic [p_seq_num_bits-1:0]             out_seq_num,
  output logic [4:0]                            out_waddr,
  output logic [31:0]                           out_wdata,
  output logic                                  out_wen,
  output logic [lp_pipe_bits-1:0]               out_pipe
);
  logic                      out_val_q, out_val_d;
  logic [31:0]               out_pc_q, out_pc_d;
  logic [p_seq_num_bits-1:0] out_seq_num_q, out_seq_num_d;
  logic [4:0]                out_waddr_q, out_waddr_d;
  logic [31:0]               out_wdata_q, out_wdata_d;
  logic                      out_wen_q, out_wen_d;
  logic [lp_pipe_bits-1:0]   out_pipe_q, out_pipe_d;
  logic [lp_pipe_bits-1:0]   rr_ptr_q, rr_ptr_d;
  logic [lp_pipe_bits-1:0]   win;
  logic [p_seq_num_bits-1:0] age;
  logic                      found, can_accept, grant;
  int                        key, best;
  // Both policies reduce to "smallest key wins, ties to lowest index":
  // the key is either the wrapped age or the distance past rr_ptr.
  always_comb begin
    win = '0;
    found = 1'b0;
    best = 0;
    age = '0;
    key = 0;
    for (int i = 0; i < p_num_pipes; i++) begin
      age = in_seq_num[i*p_seq_num_bits +: p_seq_num_bits] - head_seq_num;
      key = (p_policy == 0) ? int'(age)
          : (i >= int'(rr_ptr_q)) ? i - int'(rr_ptr_q) : i + p_num_pipes - int'(rr_ptr_q);
      if (in_val[i] && (!found || key < best)) begin
        found = 1'b1;
        best = key;
        win = lp_pipe_bits'(i);
      end
    end
  end
  assign can_accept = !out_val_q || out_rdy;
  assign grant      = can_accept && (|in_val) && !rst;
  assign in_rdy     = grant ? (p_num_pipes'(1) << win) : '0;
  always_comb begin
    out_val_d     = grant || (out_val_q && !out_rdy);
    out_pc_d      = grant ? in_pc[int'(win)*32 +: 32] : out_pc_q;
    out_seq_num_d = grant ? in_seq_num[int'(win)*p_seq_num_bits +: p_seq_num_bits] : out_seq_num_q;
    out_waddr_d   = grant ? in_waddr[int'(win)*5 +: 5] : out_waddr_q;
    out_wdata_d   = grant ? in_wdata[int'(win)*32 +: 32] : out_wdata_q;
    out_wen_d     = grant ? in_wen[win] : out_wen_q;
    out_pipe_d    = grant ? win : out_pipe_q;
    rr_ptr_d      = !grant ? rr_ptr_q : (win == lp_pipe_bits'(p_num_pipes - 1)) ? '0 : win + lp_pipe_bits'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val_q     <= 1'b0;
      out_pc_q      <= '0;
      out_seq_num_q <= '0;
      out_waddr_q   <= '0;
      out_wdata_q   <= '0;
      out_wen_q     <= 1'b0;
      out_pipe_q    <= '0;
      rr_ptr_q      <= '0;
    end else begin
      out_val_q     <= out_val_d;
      out_pc_q      <= out_pc_d;
      out_seq_num_q <= out_seq_num_d;
      out_waddr_q   <= out_waddr_d;
      out_wdata_q   <= out_wdata_d;
      out_wen_q     <= out_wen_d;
      out_pipe_q    <= out_pipe_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end
  assign out_val     = out_val_q;
  assign out_pc      = out_pc_q;
  assign out_seq_num = out_seq_num_q;
  assign out_waddr   = out_waddr_q;
  assign out_wdata   = out_wdata_q;
  assign out_wen     = out_wen_q;
  assign out_pipe    = out_pipe_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vectors on an oldest-first (2 pipes) and a
// round-robin (3 pipes) instance; expected messages queued, checked by monitors.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0]  a_in_val, a_in_rdy, a_in_wen;
  logic [63:0] a_in_pc, a_in_wdata;
  logic [5:0]  a_in_seq;
  logic [9:0]  a_in_waddr;
  logic [2:0]  a_head;
  logic        a_out_val, a_out_rdy, a_out_wen, a_out_pipe;
  logic [31:0] a_out_pc, a_out_wdata;
  logic [2:0]  a_out_seq;
  logic [4:0]  a_out_waddr;
  logic [2:0]  b_in_val, b_in_rdy, b_in_wen;
  logic [95:0] b_in_pc, b_in_wdata;
  logic [8:0]  b_in_seq;
  logic [14:0] b_in_waddr;
  logic [2:0]  b_head;
  logic        b_out_val, b_out_rdy, b_out_wen;
  logic [1:0]  b_out_pipe;
  logic [31:0] b_out_pc, b_out_wdata;
  logic [2:0]  b_out_seq;
  logic [4:0]  b_out_waddr;
  writeback_arbiter #(.p_num_pipes(2), .p_seq_num_bits(3), .p_policy(0)) u_a (
    .clk(clk), .rst(rst), .in_val(a_in_val), .in_rdy(a_in_rdy), .in_pc(a_in_pc),
    .in_seq_num(a_in_seq), .in_waddr(a_in_waddr), .in_wdata(a_in_wdata), .in_wen(a_in_wen),
    .head_seq_num(a_head), .out_val(a_out_val), .out_rdy(a_out_rdy), .out_pc(a_out_pc),
    .out_seq_num(a_out_seq), .out_waddr(a_out_waddr), .out_wdata(a_out_wdata),
    .out_wen(a_out_wen), .out_pipe(a_out_pipe));
  writeback_arbiter #(.p_num_pipes(3), .p_seq_num_bits(3), .p_policy(1)) u_b (
    .clk(clk), .rst(rst), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_pc(b_in_pc),
    .in_seq_num(b_in_seq), .in_waddr(b_in_waddr), .in_wdata(b_in_wdata), .in_wen(b_in_wen),
    .head_seq_num(b_head), .out_val(b_out_val), .out_rdy(b_out_rdy), .out_pc(b_out_pc),
    .out_seq_num(b_out_seq), .out_waddr(b_out_waddr), .out_wdata(b_out_wdata),
    .out_wen(b_out_wen), .out_pipe(b_out_pipe));
  typedef struct {
    logic [31:0] pipe, pc, seq, waddr, wdata, wen;
  } msg_t;
  msg_t qa[$], qb[$];
  msg_t ga, gb;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask
  task automatic cmp(input string t, input msg_t e, input msg_t g);
    chk({t, "_pipe"}, g.pipe, e.pipe);
    chk({t, "_pc"}, g.pc, e.pc);
    chk({t, "_seq"}, g.seq, e.seq);
    chk({t, "_waddr"}, g.waddr, e.waddr);
    chk({t, "_wdata"}, g.wdata, e.wdata);
    chk({t, "_wen"}, g.wen, e.wen);
  endtask
  function automatic msg_t m(input int p, input logic [31:0] pc, input int s, input int wa,
                             input logic [31:0] wd, input int we);
    m = '{32'(p), pc, 32'(s), 32'(wa), wd, 32'(we)};
  endfunction
  always @(negedge clk) begin
    if (!rst && a_out_val && a_out_rdy) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_extra_msg: got out_pc 0x%0h, required no message", a_out_pc);
      end else begin
        ga = '{32'(a_out_pipe), a_out_pc, 32'(a_out_seq), 32'(a_out_waddr), a_out_wdata, 32'(a_out_wen)};
        cmp("a_msg", qa.pop_front(), ga);
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && b_out_val && b_out_rdy) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_extra_msg: got out_pc 0x%0h, required no message", b_out_pc);
      end else begin
        gb = '{32'(b_out_pipe), b_out_pc, 32'(b_out_seq), 32'(b_out_waddr), b_out_wdata, 32'(b_out_wen)};
        cmp("b_msg", qb.pop_front(), gb);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_a(input int i, input logic [31:0] pc, input logic [2:0] s,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    a_in_pc[i*32 +: 32] = pc;
    a_in_seq[i*3 +: 3] = s;
    a_in_waddr[i*5 +: 5] = wa;
    a_in_wdata[i*32 +: 32] = wd;
    a_in_wen[i] = we;
  endtask
  task automatic a_drv(input logic [1:0] v, input logic r, input logic [1:0] er, input string nm);
    a_in_val = v;
    a_out_rdy = r;
    #1;
    chk(nm, 32'(a_in_rdy), 32'(er));
  endtask
  task automatic b_drv(input logic [2:0] v, input logic r, input logic [2:0] er, input string nm);
    b_in_val = v;
    b_out_rdy = r;
    #1;
    chk(nm, 32'(b_in_rdy), 32'(er));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    a_in_val = 2'b11; a_out_rdy = 1'b1; a_head = 3'd6;
    a_in_pc = '0; a_in_wdata = '0; a_in_seq = '0; a_in_waddr = '0; a_in_wen = '0;
    b_in_val = 3'b111; b_out_rdy = 1'b1; b_head = 3'd0;
    b_in_pc = '0; b_in_wdata = '0; b_in_seq = '0; b_in_waddr = '0; b_in_wen = '0;
    #2;
    chk("rst_a_in_rdy", 32'(a_in_rdy), 32'd0);
    chk("rst_b_in_rdy", 32'(b_in_rdy), 32'd0);
    chk("rst_a_out_val", 32'(a_out_val), 32'd0);
    chk("rst_b_out_val", 32'(b_out_val), 32'd0);
    chk("rst_a_out_pc", a_out_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_in_val = '0;
    b_in_val = '0;
    // oldest-first with wrap: head 6, seq 1 (age 3) vs seq 7 (age 1)
    tick();
    set_a(0, 32'h100, 3'd1, 5'd1, 32'hA0, 1'b1);
    set_a(1, 32'h104, 3'd7, 5'd2, 32'hA1, 1'b1);
    a_drv(2'b11, 1'b1, 2'b10, "wrap_first_grant");
    qa.push_back(m(1, 32'h104, 7, 2, 32'hA1, 1));
    tick();
    a_drv(2'b01, 1'b1, 2'b01, "wrap_second_grant");
    qa.push_back(m(0, 32'h100, 1, 1, 32'hA0, 1));
    // drain and grant in the same cycle
    tick();
    set_a(0, 32'h200, 3'd2, 5'd3, 32'hB0, 1'b1);
    a_drv(2'b01, 1'b1, 2'b01, "drain_grant");
    qa.push_back(m(0, 32'h200, 2, 3, 32'hB0, 1));
    tick();
    a_drv(2'b00, 1'b1, 2'b00, "idle_in_rdy");
    chk("drain_grant_val", 32'(a_out_val), 32'd1);
    chk("drain_grant_pc", a_out_pc, 32'h200);
    tick();
    a_drv(2'b00, 1'b1, 2'b00, "idle_in_rdy2");
    chk("idle_out_val_fall", 32'(a_out_val), 32'd0);
    // back-pressure for three cycles
    tick();
    set_a(0, 32'h300, 3'd6, 5'd4, 32'hC0, 1'b1);
    set_a(1, 32'h304, 3'd0, 5'd5, 32'hC1, 1'b1);
    a_drv(2'b01, 1'b1, 2'b01, "bp_load");
    qa.push_back(m(0, 32'h300, 6, 4, 32'hC0, 1));
    for (int c = 0; c < 3; c++) begin
      tick();
      a_drv(2'b10, 1'b0, 2'b00, "bp_in_rdy");
      chk("bp_hold_val", 32'(a_out_val), 32'd1);
      chk("bp_hold_pc", a_out_pc, 32'h300);
      chk("bp_hold_seq", 32'(a_out_seq), 32'd6);
    end
    tick();
    a_drv(2'b10, 1'b1, 2'b10, "bp_release");
    qa.push_back(m(1, 32'h304, 0, 5, 32'hC1, 1));
    tick();
    a_drv(2'b00, 1'b1, 2'b00, "bp_after");
    chk("bp_next_pc", a_out_pc, 32'h304);
    chk("bp_next_val", 32'(a_out_val), 32'd1);
    tick();
    a_drv(2'b00, 1'b1, 2'b00, "bp_idle");
    chk("bp_idle_val", 32'(a_out_val), 32'd0);
    // equal ages go to the lowest index
    tick();
    set_a(0, 32'h400, 3'd3, 5'd6, 32'hD0, 1'b0);
    set_a(1, 32'h404, 3'd3, 5'd7, 32'hD1, 1'b1);
    a_drv(2'b11, 1'b1, 2'b01, "tie_low_index");
    qa.push_back(m(0, 32'h400, 3, 6, 32'hD0, 0));
    tick();
    a_drv(2'b10, 1'b1, 2'b10, "tie_second");
    qa.push_back(m(1, 32'h404, 3, 7, 32'hD1, 1));
    repeat (2) begin
      tick();
      a_drv(2'b00, 1'b1, 2'b00, "tie_idle");
    end
    // round-robin fairness, all three pipes valid
    tick();
    for (int i = 0; i < 3; i++) begin
      b_in_pc[i*32 +: 32] = 32'h500 + 32'(4 * i);
      b_in_seq[i*3 +: 3] = 3'(i);
      b_in_waddr[i*5 +: 5] = 5'(8 + i);
      b_in_wdata[i*32 +: 32] = 32'hE0 + 32'(i);
      b_in_wen[i] = (i != 1);
    end
    for (int k = 0; k < 6; k++) begin
      int p;
      p = k % 3;
      if (k > 0) tick();
      b_drv(3'b111, 1'b1, 3'(1 << p), "rr_fair_grant");
      if (k > 0) chk("rr_stream_val", 32'(b_out_val), 32'd1);
      qb.push_back(m(p, 32'h500 + 32'(4 * p), p, 8 + p, 32'hE0 + 32'(p), int'(p != 1)));
    end
    tick();
    b_drv(3'b000, 1'b1, 3'b000, "rr_idle");
    tick();
    b_drv(3'b110, 1'b1, 3'b010, "rr_skip_invalid");
    qb.push_back(m(1, 32'h504, 1, 9, 32'hE1, 0));
    tick();
    b_drv(3'b000, 1'b1, 3'b000, "rr_no_grant");
    tick();
    b_drv(3'b111, 1'b1, 3'b100, "rr_ptr_held");
    qb.push_back(m(2, 32'h508, 2, 10, 32'hE2, 1));
    repeat (2) begin
      tick();
      b_drv(3'b000, 1'b1, 3'b000, "rr_idle2");
    end
    // reset while both outputs hold an unaccepted message
    tick();
    a_drv(2'b01, 1'b1, 2'b01, "pre_rst_a_grant");
    b_drv(3'b001, 1'b1, 3'b001, "pre_rst_b_grant");
    tick();
    a_drv(2'b00, 1'b0, 2'b00, "pre_rst_a_hold");
    b_drv(3'b000, 1'b0, 3'b000, "pre_rst_b_hold");
    tick();
    chk("pre_rst_a_val", 32'(a_out_val), 32'd1);
    chk("pre_rst_b_val", 32'(b_out_val), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_a_val", 32'(a_out_val), 32'd0);
    chk("async_rst_b_val", 32'(b_out_val), 32'd0);
    chk("async_rst_a_pc", a_out_pc, 32'd0);
    chk("async_rst_b_pipe", 32'(b_out_pipe), 32'd0);
    chk("async_rst_b_seq", 32'(b_out_seq), 32'd0);
    a_out_rdy = 1'b1;
    b_out_rdy = 1'b1;
    a_in_val = 2'b11;
    #1;
    chk("rst_hold_in_rdy", 32'(a_in_rdy), 32'd0);
    tick();
    rst = 1'b0;
    a_in_val = 2'b00;
    #1;
    chk("no_stale_a", 32'(a_out_val), 32'd0);
    chk("no_stale_b", 32'(b_out_val), 32'd0);
    tick();
    b_drv(3'b111, 1'b1, 3'b001, "rr_ptr_after_rst");
    qb.push_back(m(0, 32'h500, 0, 8, 32'hE0, 1));
    tick();
    b_drv(3'b000, 1'b1, 3'b000, "post_rst_idle");
    chk("post_rst_a_val", 32'(a_out_val), 32'd0);
    tick();
    b_drv(3'b000, 1'b1, 3'b000, "post_rst_idle2");
    tick();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
